// File: rtl/ram_gen_pkg.sv
// Shared types and helpers for the generated single-port block RAM family.
package ram_gen_pkg;

  // Read-during-write behaviour of the single port.
  typedef enum logic [1:0] {
    WRITE_FIRST = 2'd0,
    READ_FIRST  = 2'd1,
    NO_CHANGE   = 2'd2
  } write_mode_e;

  // Array-clear engine states.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // A word must split into a whole number of non-empty write-enable lanes.
  function automatic bit width_ok(int data_width, int byte_width);
    if (data_width <= 0 || byte_width <= 0) return 1'b0;
    return (data_width % byte_width) == 0;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Array-clear sequencer: walks every address writing INIT_VAL while BUSY is
// high, and otherwise passes the user write port through to the array.
module ram_clr_seq
  import ram_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    NB         = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  user_en,
  input  logic [NB-1:0]         user_we,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  input  logic [DATA_WIDTH-1:0] user_di,
  output logic                  busy,
  output logic [NB-1:0]         mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_di
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  clr_state_e            state;
  logic [ADDR_WIDTH-1:0] cnt;

  // Clear FSM: counter and BUSY are registered alongside the state so BUSY
  // is glitch-free and drops on the edge that writes the last address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          // Counter wraps naturally to 0 after the last address.
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // While clearing the engine owns the whole word; otherwise the user port
  // writes only the enabled lanes, and only when the access is accepted.
  assign mem_we   = busy ? {NB{1'b1}} : (user_we & {NB{user_en}});
  assign mem_addr = busy ? cnt        : user_addr;
  assign mem_di   = busy ? INIT_VAL   : user_di;

endmodule

// File: rtl/ramb_sp_gen.sv
// Parametrised single-port synchronous block RAM with byte-lane writes,
// selectable read-during-write mode, optional output register, valid strobe
// and a built-in array-clear engine.
module ramb_sp_gen
  import ram_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    BYTE_WIDTH = 8,
  parameter int                    WRITE_MODE = 0,
  parameter int                    DO_REG     = 0,
  parameter logic [DATA_WIDTH-1:0] SRVAL      = '0,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             EN,
  input  logic                             SSR,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WE,
  input  logic [ADDR_WIDTH-1:0]            ADDR,
  input  logic [DATA_WIDTH-1:0]            DI,
  input  logic                             CLR,
  output logic                             BUSY,
  output logic [DATA_WIDTH-1:0]            DO,
  output logic                             DO_VALID
);

  localparam int          NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int          DEPTH = 2 ** ADDR_WIDTH;
  localparam write_mode_e MODE  = write_mode_e'(WRITE_MODE[1:0]);

  // Elaboration-time legality checks.
  if (!width_ok(DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_width
    $error("ramb_sp_gen: DATA_WIDTH must be a non-zero multiple of BYTE_WIDTH");
  end
  if (WRITE_MODE < 0 || WRITE_MODE > 2) begin : g_bad_mode
    $error("ramb_sp_gen: WRITE_MODE must be 0, 1 or 2");
  end
  if (DO_REG < 0 || DO_REG > 1) begin : g_bad_doreg
    $error("ramb_sp_gen: DO_REG must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  busy;
  logic                  access;
  logic [NB-1:0]         mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_di;

  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] wf_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  nc_block;

  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;

  // The user port is ignored entirely while the clear engine runs.
  assign access = EN & ~busy;

  ram_clr_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NB         (NB),
    .INIT_VAL   (INIT_VAL)
  ) u_clr_seq (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clr       (CLR),
    .user_en   (access),
    .user_we   (WE),
    .user_addr (ADDR),
    .user_di   (DI),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_di    (mem_di)
  );

  // Byte-lane array write from the muxed (user or clear) write port.
  // NOTE: the storage array has no reset; only control and output state are
  // reset, which keeps the array mappable onto block RAM.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we[i]) begin
        mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_di[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign old_word = mem[ADDR];

  // Post-write view of the addressed word: written lanes take DI, the rest
  // keep their old contents.
  // NOTE: combinational blocks use blocking '=' and assign a default first,
  // so every path drives the result and no latch is inferred.
  always_comb begin
    wf_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (WE[i]) begin
        wf_word[i*BYTE_WIDTH +: BYTE_WIDTH] = DI[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rd_word  = (MODE == WRITE_FIRST) ? wf_word : old_word;
  assign nc_block = (MODE == NO_CHANGE) && (WE != '0);

  // First output stage: captures the read result, SRVAL on SSR, or holds.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_data  <= SRVAL;
      s1_valid <= 1'b0;
    end else if (busy || !EN) begin
      s1_valid <= 1'b0;
    end else if (SSR) begin
      s1_data  <= SRVAL;
      s1_valid <= 1'b0;
    end else if (nc_block) begin
      s1_valid <= 1'b0;
    end else begin
      s1_data  <= rd_word;
      s1_valid <= 1'b1;
    end
  end

  if (DO_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] s2_data;
    logic                  s2_valid;

    // Optional output register: advances every cycle outside a clear.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        s2_data  <= SRVAL;
        s2_valid <= 1'b0;
      end else if (busy) begin
        s2_valid <= 1'b0;
      end else begin
        s2_data  <= s1_data;
        s2_valid <= s1_valid;
      end
    end

    assign out_data  = s2_data;
    assign out_valid = s2_valid;
  end else begin : g_no_out_reg
    assign out_data  = s1_data;
    assign out_valid = s1_valid;
  end

  // A read accepted on the edge that starts a clear never reports valid.
  assign DO       = out_data;
  assign DO_VALID = out_valid & ~busy;
  assign BUSY     = busy;

endmodule

// File: tb/tb_ramb_sp_gen.sv
// Self-checking bench: three RAM instances (write-first/1-cycle,
// read-first/2-cycle, no-change/1-cycle) share one stimulus stream and are
// compared against a behavioural model of the storage and output rules.
module tb_ramb_sp_gen;

  localparam int          DW    = 32;
  localparam int          AW    = 4;
  localparam int          NB    = DW / 8;
  localparam int          DEPTH = 2 ** AW;
  localparam logic [31:0] SRV   = 32'h0BAD_F00D;
  localparam logic [31:0] INIT  = 32'h5A5A_5A5A;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          ssr = 1'b0;
  logic [NB-1:0] we = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] di = '0;
  logic          clr = 1'b0;

  logic [2:0]    busy_o;
  logic [2:0]    dv_o;
  logic [DW-1:0] do_o [3];

  int tests = 0;
  int fails = 0;

  // Instance configuration: write mode and output-register setting.
  int mode_k  [3] = '{0, 1, 2};
  int doreg_k [3] = '{0, 1, 0};

  always #5 clk = ~clk;

  ramb_sp_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .WRITE_MODE(0),
                .DO_REG(0), .SRVAL(SRV), .INIT_VAL(INIT)) dut_wf (
    .CLK(clk), .RST_N(rst_n), .EN(en), .SSR(ssr), .WE(we), .ADDR(addr), .DI(di),
    .CLR(clr), .BUSY(busy_o[0]), .DO(do_o[0]), .DO_VALID(dv_o[0]));

  ramb_sp_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .WRITE_MODE(1),
                .DO_REG(1), .SRVAL(SRV), .INIT_VAL(INIT)) dut_rf (
    .CLK(clk), .RST_N(rst_n), .EN(en), .SSR(ssr), .WE(we), .ADDR(addr), .DI(di),
    .CLR(clr), .BUSY(busy_o[1]), .DO(do_o[1]), .DO_VALID(dv_o[1]));

  ramb_sp_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .WRITE_MODE(2),
                .DO_REG(0), .SRVAL(SRV), .INIT_VAL(INIT)) dut_nc (
    .CLK(clk), .RST_N(rst_n), .EN(en), .SSR(ssr), .WE(we), .ADDR(addr), .DI(di),
    .CLR(clr), .BUSY(busy_o[2]), .DO(do_o[2]), .DO_VALID(dv_o[2]));

  // ---------------- behavioural reference model ----------------
  logic [DW-1:0] mem_m [DEPTH];
  int            clr_left;
  int            clr_ptr;
  logic [DW-1:0] st_d  [3];
  bit            st_v  [3];
  logic [DW-1:0] out_d [3];
  bit            out_v [3];

  task automatic model_reset();
    clr_left = 0;
    clr_ptr  = 0;
    for (int k = 0; k < 3; k++) begin
      st_d[k] = SRV; st_v[k] = 1'b0;
      out_d[k] = SRV; out_v[k] = 1'b0;
    end
  endtask

  // Apply one clock edge's worth of spec rules using the pre-edge inputs.
  task automatic model_step();
    logic [DW-1:0] old_w, new_w, res_d;
    bit            res_v, res_hold;
    if (clr_left > 0) begin
      mem_m[clr_ptr] = INIT;
      clr_ptr  = (clr_ptr + 1) % DEPTH;
      clr_left = clr_left - 1;
      for (int k = 0; k < 3; k++) begin
        st_v[k]  = 1'b0;
        out_v[k] = 1'b0;
      end
    end else begin
      old_w = mem_m[addr];
      new_w = old_w;
      if (en) begin
        for (int i = 0; i < NB; i++)
          if (we[i]) new_w[i*8 +: 8] = di[i*8 +: 8];
      end
      for (int k = 0; k < 3; k++) begin
        res_hold = 1'b1;
        res_v    = 1'b0;
        res_d    = '0;
        if (en) begin
          if (ssr) begin
            res_hold = 1'b0;
            res_d    = SRV;
          end else if (!(mode_k[k] == 2 && we != '0)) begin
            res_hold = 1'b0;
            res_d    = (mode_k[k] == 1) ? old_w : new_w;
            res_v    = 1'b1;
          end
        end
        // Two-cycle latency: the previous result moves to the output first.
        if (doreg_k[k] != 0) begin
          out_d[k] = st_d[k];
          out_v[k] = st_v[k];
        end
        if (!res_hold) st_d[k] = res_d;
        st_v[k] = res_v;
        if (doreg_k[k] == 0) begin
          out_d[k] = st_d[k];
          out_v[k] = st_v[k];
        end
      end
      if (en) mem_m[addr] = new_w;
      if (clr) begin
        clr_left = DEPTH;
        clr_ptr  = 0;
      end
    end
  endtask

  function automatic logic exp_busy();
    return clr_left > 0;
  endfunction

  function automatic logic exp_valid(int k);
    return out_v[k] && (clr_left == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; ssr = 1'b0; we = '0; clr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (busy_o[k] !== 1'b0 || dv_o[k] !== 1'b0 || do_o[k] !== SRV) begin
        fails++;
        $display("FAIL reset inst%0d: busy=%b valid=%b do=%h, want 0 0 %h",
                 k, busy_o[k], dv_o[k], do_o[k], SRV);
      end
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // Bring the array to a known state for the rest of the run.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (DEPTH) tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({busy_o[k], dv_o[k], do_o[k]} !== {exp_busy(), exp_valid(k), out_d[k]}) begin
        fails++;
        $display("FAIL init_clear inst%0d: got busy=%b valid=%b do=%h, want busy=%b valid=%b do=%h",
                 k, busy_o[k], dv_o[k], do_o[k], exp_busy(), exp_valid(k), out_d[k]);
      end
    end
  endtask

  task automatic test_basic();
    en = 1'b1; we = '1; addr = 4'd3; di = 32'h0000_00A5;
    tick();
    we = '0;
    tick();
    tests++;
    if (do_o[0] !== 32'h0000_00A5 || dv_o[0] !== 1'b1) begin
      fails++;
      $display("FAIL basic_read: do=%h valid=%b, want 000000a5 1", do_o[0], dv_o[0]);
    end
    en = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({busy_o[k], dv_o[k], do_o[k]} !== {exp_busy(), exp_valid(k), out_d[k]}) begin
        fails++;
        $display("FAIL basic_model inst%0d: got valid=%b do=%h, want valid=%b do=%h",
                 k, dv_o[k], do_o[k], exp_valid(k), out_d[k]);
      end
    end
  endtask

  task automatic test_write_modes();
    en = 1'b1; we = '1; addr = 4'd5; di = 32'h11;
    tick();
    di = 32'h22;
    tick();
    tests++;
    if (do_o[0] !== 32'h22 || dv_o[0] !== 1'b1) begin
      fails++;
      $display("FAIL wf_same_cycle: do=%h valid=%b, want 00000022 1", do_o[0], dv_o[0]);
    end
    tests++;
    if (do_o[2] !== 32'hA5 || dv_o[2] !== 1'b0) begin
      fails++;
      $display("FAIL nc_hold: do=%h valid=%b, want 000000a5 0", do_o[2], dv_o[2]);
    end
    we = '0;
    tick();
    tests++;
    if (do_o[1] !== 32'h11 || dv_o[1] !== 1'b1) begin
      fails++;
      $display("FAIL rf_old_word: do=%h valid=%b, want 00000011 1", do_o[1], dv_o[1]);
    end
    tests++;
    if (do_o[2] !== 32'h22 || dv_o[2] !== 1'b1) begin
      fails++;
      $display("FAIL nc_read: do=%h valid=%b, want 00000022 1", do_o[2], dv_o[2]);
    end
    en = 1'b0;
    tick();
    tests++;
    if (do_o[1] !== 32'h22 || dv_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL rf_followup: do=%h wf_valid=%b, want 00000022 0", do_o[1], dv_o[0]);
    end
  endtask

  task automatic test_byte_lanes();
    en = 1'b1; we = '1; addr = 4'd7; di = 32'hFFFF_FFFF;
    tick();
    we = 4'b0101; di = 32'hDDCC_BBAA;
    tick();
    tests++;
    if (do_o[0] !== 32'hFFCC_FFAA) begin
      fails++;
      $display("FAIL lanes_wf: do=%h, want ffccffaa", do_o[0]);
    end
    we = '0;
    tick();
    tests++;
    if (do_o[0] !== 32'hFFCC_FFAA || do_o[2] !== 32'hFFCC_FFAA) begin
      fails++;
      $display("FAIL lanes_read: wf=%h nc=%h, want ffccffaa", do_o[0], do_o[2]);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    en = 1'b1; we = '1;
    for (int a = 0; a < 3; a++) begin
      addr = AW'(a); di = 32'h1000_0000 + 32'(a);
      tick();
    end
    we = '0;
    addr = 4'd0; tick();
    addr = 4'd1; ssr = 1'b1; tick();
    tests++;
    if (do_o[1] !== 32'h1000_0000 || dv_o[1] !== 1'b1 || do_o[0] !== SRV || dv_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL pipe_c2: reg do=%h valid=%b wf do=%h valid=%b, want 10000000 1 %h 0",
               do_o[1], dv_o[1], do_o[0], dv_o[0], SRV);
    end
    addr = 4'd2; ssr = 1'b0; tick();
    tests++;
    if (do_o[1] !== SRV || dv_o[1] !== 1'b0 || do_o[0] !== 32'h1000_0002) begin
      fails++;
      $display("FAIL pipe_c3: reg do=%h valid=%b wf do=%h, want %h 0 10000002",
               do_o[1], dv_o[1], do_o[0], SRV);
    end
    en = 1'b0; tick();
    tests++;
    if (do_o[1] !== 32'h1000_0002 || dv_o[1] !== 1'b1) begin
      fails++;
      $display("FAIL pipe_c4: do=%h valid=%b, want 10000002 1", do_o[1], dv_o[1]);
    end
    tick();
    tests++;
    if (do_o[1] !== 32'h1000_0002 || dv_o[1] !== 1'b0) begin
      fails++;
      $display("FAIL pipe_drain: do=%h valid=%b, want 10000002 0", do_o[1], dv_o[1]);
    end
  endtask

  task automatic test_clear();
    int cnt = 0;
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    // Hammer the port while busy; a second CLR mid-clear must be ignored.
    while (busy_o[0] && cnt < DEPTH + 8) begin
      cnt++;
      en = 1'b1; we = '1; ssr = 1'($urandom_range(0, 1));
      addr = AW'($urandom); di = $urandom;
      clr = (cnt == 5);
      tick();
      clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tests++;
        if ({busy_o[k], dv_o[k], do_o[k]} !== {exp_busy(), exp_valid(k), out_d[k]}) begin
          fails++;
          $display("FAIL clear_busy inst%0d: got busy=%b valid=%b do=%h, want busy=%b valid=%b do=%h",
                   k, busy_o[k], dv_o[k], do_o[k], exp_busy(), exp_valid(k), out_d[k]);
        end
      end
    end
    idle_inputs();
    tests++;
    if (cnt != DEPTH) begin
      fails++;
      $display("FAIL clear_length: busy cycles=%0d, want %0d", cnt, DEPTH);
    end
    en = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      addr = AW'(a);
      tick();
      tests++;
      if (do_o[0] !== INIT || dv_o[0] !== 1'b1) begin
        fails++;
        $display("FAIL clear_readback addr %0d: do=%h valid=%b, want %h 1", a, do_o[0], dv_o[0], INIT);
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int cnt = 0;
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (busy_o[k] !== 1'b0 || dv_o[k] !== 1'b0 || do_o[k] !== SRV) begin
        fails++;
        $display("FAIL reset_mid_clear inst%0d: busy=%b valid=%b do=%h, want 0 0 %h",
                 k, busy_o[k], dv_o[k], do_o[k], SRV);
      end
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    while (busy_o[0] && cnt < DEPTH + 8) begin
      cnt++;
      tick();
    end
    tests++;
    if (cnt != DEPTH) begin
      fails++;
      $display("FAIL reclear_length: busy cycles=%0d, want %0d", cnt, DEPTH);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      en   = ($urandom_range(0, 3) != 0);
      ssr  = ($urandom_range(0, 7) == 0);
      we   = NB'($urandom);
      addr = AW'($urandom);
      di   = $urandom;
      clr  = ($urandom_range(0, 99) == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        tests++;
        if ({busy_o[k], dv_o[k], do_o[k]} !== {exp_busy(), exp_valid(k), out_d[k]}) begin
          fails++;
          $display("FAIL random cycle %0d inst%0d: got busy=%b valid=%b do=%h, want busy=%b valid=%b do=%h",
                   n, k, busy_o[k], dv_o[k], do_o[k], exp_busy(), exp_valid(k), out_d[k]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_write_modes();
    test_byte_lanes();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
